// File: rtl/spi_txn_scheduler_if.sv
// Request/response and spi_master-facing signals of spi_txn_scheduler.
//   slave  : the scheduler (takes client requests and master status, drives
//            grants, responses and master start/address/data)
//   master : the environment (clients plus the spi_master model)
// Client side : req, req_rw, req_addr0/1, req_wdata0/1 -> gnt, resp_valid,
//               resp_rdata, resp_err, busy
// Master side : m_start_wr, m_start_re, m_addr, m_wdata <- m_rdata, m_done
interface spi_txn_scheduler_if;
    logic [1:0] req;
    logic [1:0] req_rw;
    logic [7:0] req_addr0;
    logic [7:0] req_addr1;
    logic [7:0] req_wdata0;
    logic [7:0] req_wdata1;
    logic [1:0] gnt;
    logic [1:0] resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       busy;
    logic       m_start_wr;
    logic       m_start_re;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic       m_done;

    modport slave (
        input  req, req_rw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  m_rdata, m_done,
        output gnt, resp_valid, resp_rdata, resp_err, busy,
        output m_start_wr, m_start_re, m_addr, m_wdata
    );

    modport master (
        output req, req_rw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output m_rdata, m_done,
        input  gnt, resp_valid, resp_rdata, resp_err, busy,
        input  m_start_wr, m_start_re, m_addr, m_wdata
    );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Two-client round-robin transaction scheduler in front of spi_master.
// Grants one request at a time, holds the master start level for START_HOLD
// cycles, waits for m_done (bounded by TIMEOUT) and returns read data or a
// timeout error to the owning client.
// Ports:
//   clock : single clock
//   reset : synchronous, active-high
//   bus   : spi_txn_scheduler_if.slave (client handshake + spi_master signals)
// All outputs are registered; every output register updates on the edge after
// the state that computes it.
module spi_txn_scheduler #(
    parameter int unsigned          TIMEOUT_W  = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 16'd50000,
    parameter logic [2:0]           START_HOLD = 3'd4
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_txn_scheduler_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT - TIMEOUT_W'(1);

    logic [1:0]           r_state,      w_state_nxt;
    logic                 r_last_gnt,   w_last_gnt_nxt;
    logic                 r_owner,      w_owner_nxt;
    logic                 r_cur_rw,     w_cur_rw_nxt;
    logic [7:0]           r_cur_addr,   w_cur_addr_nxt;
    logic [7:0]           r_cur_wdata,  w_cur_wdata_nxt;
    logic [2:0]           r_hold_cnt,   w_hold_cnt_nxt;
    logic [TIMEOUT_W-1:0] r_to_cnt,     w_to_cnt_nxt;
    logic [1:0]           r_gnt,        w_gnt_nxt;
    logic [1:0]           r_resp_valid, w_resp_valid_nxt;
    logic [7:0]           r_resp_rdata, w_resp_rdata_nxt;
    logic                 r_resp_err,   w_resp_err_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_start_wr,   w_start_wr_nxt;
    logic                 r_start_re,   w_start_re_nxt;
    logic                 w_pick;

    // Client to grant: the lone requester, or the one not granted last time.
    assign w_pick = (bus.req == 2'b11) ? ~r_last_gnt : bus.req[1];

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= 1'b1;
            r_owner      <= 1'b0;
            r_cur_rw     <= 1'b0;
            r_cur_addr   <= 8'h00;
            r_cur_wdata  <= 8'h00;
            r_hold_cnt   <= 3'd0;
            r_to_cnt     <= '0;
            r_gnt        <= 2'b00;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= 8'h00;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_start_wr   <= 1'b0;
            r_start_re   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_gnt   <= w_last_gnt_nxt;
            r_owner      <= w_owner_nxt;
            r_cur_rw     <= w_cur_rw_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_cur_wdata  <= w_cur_wdata_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_busy       <= w_busy_nxt;
            r_start_wr   <= w_start_wr_nxt;
            r_start_re   <= w_start_re_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_gnt_nxt   = r_last_gnt;
        w_owner_nxt      = r_owner;
        w_cur_rw_nxt     = r_cur_rw;
        w_cur_addr_nxt   = r_cur_addr;
        w_cur_wdata_nxt  = r_cur_wdata;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_gnt_nxt        = 2'b00;
        w_resp_valid_nxt = 2'b00;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_start_wr_nxt   = 1'b0;
        w_start_re_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    w_gnt_nxt       = w_pick ? 2'b10 : 2'b01;
                    w_cur_rw_nxt    = bus.req_rw[w_pick];
                    w_cur_addr_nxt  = w_pick ? bus.req_addr1  : bus.req_addr0;
                    w_cur_wdata_nxt = w_pick ? bus.req_wdata1 : bus.req_wdata0;
                    w_owner_nxt     = w_pick;
                    w_last_gnt_nxt  = w_pick;
                    w_hold_cnt_nxt  = 3'd0;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Start stays high while hold_cnt runs 0..START_HOLD-1.
                if (r_hold_cnt == START_HOLD) begin
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = S_WAIT;
                end else begin
                    w_start_wr_nxt = r_cur_rw;
                    w_start_re_nxt = ~r_cur_rw;
                    w_hold_cnt_nxt = r_hold_cnt + 3'd1;
                end
            end
            S_WAIT: begin
                w_to_cnt_nxt = r_to_cnt + TIMEOUT_W'(1);
                // m_done takes priority over a simultaneous timeout.
                if (bus.m_done) begin
                    w_resp_rdata_nxt = r_cur_rw ? 8'h00 : bus.m_rdata;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = S_RESP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_resp_rdata_nxt = 8'h00;
                    w_resp_err_nxt   = 1'b1;
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_valid_nxt = r_owner ? 2'b10 : 2'b01;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.gnt        = r_gnt;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.busy       = r_busy;
    assign bus.m_start_wr = r_start_wr;
    assign bus.m_start_re = r_start_re;
    assign bus.m_addr     = r_cur_addr;
    assign bus.m_wdata    = r_cur_wdata;

endmodule
